fma_add_pipe: RTL and testbench

//   Two-stage pipelined significand adder for the FMA datapath; sits directly downstream of the

---
 rtl/fma_add_pipe.sv | 104 ++++++++++
 tb/tb_fma_add_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_add_pipe.sv
// Two-stage significand adder for the FMA datapath: stage 1 forms product + (inverted) aligned
// addend, stage 2 converts the two's-complement result to sign-magnitude for the normalizer.
module fma_add_pipe #(
  parameter int AW = 158,
  parameter int PW = 106
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] rp,
  input  logic [AW-1:0] t,
  input  logic          bs,
  input  logic          ps,
  input  logic          killprod,
  input  logic          invz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] sum,
  output logic          negsum,
  output logic          sticky,
  output logic          sumzero
);

  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s1_load;
  logic          s2_load;

  logic [AW-1:0] p;
  logic [AW-1:0] ti;
  logic          cin;
  logic [AW:0]   add_full;
  logic          neg_c;

  logic [AW-1:0] s1_sum;
  logic          s1_neg;
  logic          s1_bs;
  logic          s1_ps;

  logic [AW-1:0] mag_c;
  logic          sticky_c;

  assign s1_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s1_adv;
  assign out_valid = s2_valid;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s1_adv & s1_valid;

  // With a sticky addend the true addend exceeds t, so the +1 of the negation is withheld.
  assign p        = killprod ? '0 : {{(AW-PW){1'b0}}, rp};
  assign ti       = invz ? ~t : t;
  assign cin      = invz & ~bs;
  assign add_full = {1'b0, p} + {1'b0, ti} + {{AW{1'b0}}, cin};
  assign neg_c    = invz & ~add_full[AW];

  assign mag_c    = s1_neg ? (~s1_sum + {{(AW-1){1'b0}}, ~s1_bs}) : s1_sum;
  assign sticky_c = s1_bs | s1_ps;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_adv)   s2_valid <= s1_valid;
    end
  end

  // Datapath registers are left alone by flush; only the valids matter downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sum <= '0;
      s1_neg <= 1'b0;
      s1_bs  <= 1'b0;
      s1_ps  <= 1'b0;
    end else if (s1_load && !flush) begin
      s1_sum <= add_full[AW-1:0];
      s1_neg <= neg_c;
      s1_bs  <= bs;
      s1_ps  <= ps;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum     <= '0;
      negsum  <= 1'b0;
      sticky  <= 1'b0;
      sumzero <= 1'b0;
    end else if (s2_load && !flush) begin
      sum     <= mag_c;
      negsum  <= s1_neg;
      sticky  <= sticky_c;
      sumzero <= (mag_c == '0) & ~sticky_c;
    end
  end

endmodule

// File: tb/tb_fma_add_pipe.sv
// Self-checking bench for fma_add_pipe: directed vector table, back-pressure/flush/reset
// sequences, and a randomized stream scored against a magnitude-compare reference model.
module tb_fma_add_pipe;
  localparam int AW = 158;
  localparam int PW = 106;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] rp;
  logic [AW-1:0] t;
  logic          bs, ps, killprod, invz;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic          negsum, sticky, sumzero;

  fma_add_pipe #(.AW(AW), .PW(PW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rp(rp), .t(t), .bs(bs), .ps(ps), .killprod(killprod), .invz(invz),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .negsum(negsum), .sticky(sticky), .sumzero(sumzero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] sum;
    logic          neg;
    logic          st;
    logic          z;
  } res_t;

  typedef struct {
    logic [PW-1:0] rp;
    logic [AW-1:0] t;
    logic          bs, ps, kp, inv;
    res_t          e;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  res_t cur_exp;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed arithmetic on magnitudes; a sticky addend is slightly larger than t.
  function automatic res_t model(input logic [PW-1:0] a_rp, input logic [AW-1:0] a_t,
                                 input logic a_bs, input logic a_ps, input logic a_kp,
                                 input logic a_inv);
    res_t r;
    logic [AW:0] pv, tv, s;
    pv = a_kp ? '0 : {{(AW+1-PW){1'b0}}, a_rp};
    tv = {1'b0, a_t};
    r.neg = 1'b0;
    if (!a_inv) s = pv + tv;
    else if (a_bs) begin
      if (pv > tv) s = pv - tv - 1;
      else begin s = tv - pv; r.neg = 1'b1; end
    end else begin
      if (pv >= tv) s = pv - tv;
      else begin s = tv - pv; r.neg = 1'b1; end
    end
    r.sum = s[AW-1:0];
    r.st  = a_bs | a_ps;
    r.z   = (r.sum == '0) && !r.st;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_w();
    logic [159:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) acc = {acc[127:0], 32'($urandom())};
    return acc[AW-1:0];
  endfunction

  task automatic drive_rand();
    logic [AW-1:0] w;
    w        = rand_w();
    rp       = w[PW-1:0];
    bs       = 1'($urandom_range(0, 1));
    ps       = 1'($urandom_range(0, 1));
    killprod = ($urandom_range(0, 7) == 0);
    invz     = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       t = rand_w();
      1:       t = {{(AW-PW){1'b0}}, rand_w()[PW-1:0]};
      2:       t = {{(AW-PW){1'b0}}, rp};
      default: t = {{(AW-PW){1'b0}}, rp} + (($urandom_range(0, 1) != 0) ? 158'd1 : {AW{1'b1}});
    endcase
    cur_exp = model(rp, t, bs, ps, killprod, invz);
  endtask

  // One clock: score the transfers that happen at the coming edge, then advance.
  task automatic tick();
    res_t e;
    #1;
    if (in_valid && in_ready && !flush) exp_q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got out_valid=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.sum);
        chk("negsum", AW'(negsum), AW'(e.neg));
        chk("sticky", AW'(sticky), AW'(e.st));
        chk("sumzero", AW'(sumzero), AW'(e.z));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_vec(input vec_t v);
    rp = v.rp; t = v.t; bs = v.bs; ps = v.ps; killprod = v.kp; invz = v.inv;
    cur_exp = v.e;
  endtask

  initial begin
    logic [AW-1:0] held;
    logic [AW-1:0] p104;
    p104 = 158'd1 << 104;

    vecs[0] = '{rp: PW'(p104), t: p104, bs: 0, ps: 0, kp: 0, inv: 0, e: '{158'd1 << 105, 0, 0, 0}};
    vecs[1] = '{rp: PW'(p104), t: p104, bs: 0, ps: 0, kp: 0, inv: 1, e: '{158'd0, 0, 0, 1}};
    vecs[2] = '{rp: 106'd1, t: 158'd3, bs: 0, ps: 0, kp: 0, inv: 1, e: '{158'd2, 1, 0, 0}};
    vecs[3] = '{rp: 106'd1, t: 158'd3, bs: 1, ps: 0, kp: 0, inv: 1, e: '{158'd2, 1, 1, 0}};
    vecs[4] = '{rp: {PW{1'b1}}, t: 158'd5, bs: 0, ps: 1, kp: 1, inv: 0, e: '{158'd5, 0, 1, 0}};
    vecs[5] = '{rp: 106'd5, t: 158'd5, bs: 1, ps: 0, kp: 0, inv: 1, e: '{158'd0, 1, 1, 0}};
    vecs[6] = '{rp: {PW{1'b1}}, t: 158'd0, bs: 0, ps: 0, kp: 0, inv: 0,
                e: '{(158'd1 << 106) - 158'd1, 0, 0, 0}};
    vecs[7] = '{rp: 106'd0, t: 158'd0, bs: 0, ps: 0, kp: 0, inv: 1, e: '{158'd0, 0, 0, 1}};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rp = '0; t = '0; bs = 0; ps = 0; killprod = 0; invz = 0; cur_exp = '0;
    #12;
    chk("rst_in_ready", AW'(in_ready), AW'(1));
    chk("rst_out_valid", AW'(out_valid), AW'(0));
    chk("rst_sum", sum, '0);
    chk("rst_flags", AW'({negsum, sticky, sumzero}), AW'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors with exact two-cycle latency check
    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("lat1_v%0d", i), AW'(out_valid), AW'(0));
      tick();
      chk($sformatf("lat2_v%0d", i), AW'(out_valid), AW'(1));
      tick();
    end
    drain();

    // Back-pressure: 4 ops, stalled output for 3 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_rand(); tick();
    drive_rand(); tick();
    #1;
    chk("bp_in_ready_low", AW'(in_ready), AW'(0));
    chk("bp_out_valid", AW'(out_valid), AW'(1));
    held = sum;
    drive_rand();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold_sum_%0d", c), sum, held);
      chk($sformatf("bp_hold_valid_%0d", c), AW'(out_valid), AW'(1));
    end
    out_ready = 1'b1;
    tick();
    drive_rand();
    tick();
    drain();

    // Flush with two ops in flight and a concurrent input
    in_valid = 1'b1;
    drive_rand(); tick();
    drive_rand(); tick();
    drive_rand();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", AW'(out_valid), AW'(0));
    tick();
    chk("flush_out_valid2", AW'(out_valid), AW'(0));
    chk("flush_in_ready", AW'(in_ready), AW'(1));

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    drive_rand(); tick();
    drive_rand(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", AW'(out_valid), AW'(0));
    chk("arst_in_ready", AW'(in_ready), AW'(1));
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized stream with random back-pressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive_rand();
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
